edsac_main_control: RTL and testbench

- Main control sequencer for the EDSAC control section.
- Steps the machine through initial-orders start, then alternating order and execute major cycles. Extends execute for multiply orders and handles stop (Z order / stop button), start and single-step.
- Drives the order coder's starter/extended qualifiers, order-tank load and sequence-control-tank (SCT) increment/jump strobes.
- Consumes decoded op lines and the accumulator sign.

---
 rtl/edsac_main_control.sv | 194 +++++++++++++++++++
 tb/tb_edsac_main_control.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edsac_main_control.sv
// EDSAC main control sequencer: walks the machine through the initial-orders
// starter, then alternating order and execute major cycles, with extended
// execute for multiply orders and stop/start/single-step handling.
module edsac_main_control #(
    parameter int MINOR_CYCLES = 16,
    parameter int EXT_MAJORS   = 1,
    parameter int MC_W         = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_minor_tick,
    input  logic            i_start_btn,
    input  logic            i_stop_btn,
    input  logic            i_single_step,
    input  logic            i_op_z,
    input  logic            i_op_e,
    input  logic            i_op_g,
    input  logic            i_op_v,
    input  logic            i_op_n,
    input  logic            i_acc_neg,
    output logic [MC_W-1:0] o_minor_count,
    output logic            o_major_end,
    output logic            o_starter,
    output logic            o_starter_neg,
    output logic            o_order_stage,
    output logic            o_exec_stage,
    output logic            o_extended,
    output logic            o_extended_neg,
    output logic            o_order_tank_load,
    output logic            o_sct_inc,
    output logic            o_sct_load,
    output logic            o_running,
    output logic            o_halted_z
);

    localparam int EW = (EXT_MAJORS > 1) ? $clog2(EXT_MAJORS) : 1;
    localparam logic [MC_W-1:0] MC_LAST  = MC_W'(MINOR_CYCLES - 1);
    localparam logic [EW-1:0]   EXT_INIT = EW'(EXT_MAJORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STARTER,
        S_ORDER,
        S_EXEC,
        S_EXEC_EXT,
        S_STOPPED
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [MC_W-1:0] r_minorCount;
    logic [EW-1:0]   r_extCnt;
    logic            r_stopReq;
    logic            r_opZ;
    logic            r_opE;
    logic            r_opG;
    logic            r_opV;
    logic            r_opN;
    logic            r_starter;
    logic            r_orderStage;
    logic            r_execStage;
    logic            r_extended;
    logic            r_running;
    logic            r_haltedZ;
    logic            r_orderEntry;
    logic            r_tankLoad;
    logic            r_sctInc;
    logic            r_sctLoad;
    logic            w_majorEnd;
    logic            w_running;
    logic            w_orderDone;
    logic            w_jump;
    logic            w_stopReqEff;

    assign w_majorEnd   = i_minor_tick && (r_minorCount == MC_LAST);
    assign w_running    = (r_state == S_STARTER) || (r_state == S_ORDER) ||
                          (r_state == S_EXEC)    || (r_state == S_EXEC_EXT);
    assign w_stopReqEff = r_stopReq || (w_running && i_stop_btn);
    assign w_jump       = (r_opE && !i_acc_neg) || (r_opG && i_acc_neg);

    // Minor cycle counter runs in every state and wraps at the end of each major cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_minorCount <= '0;
        end else if (i_minor_tick) begin
            r_minorCount <= (r_minorCount == MC_LAST) ? '0 : r_minorCount + 1'b1;
        end
    end

    // Next-state selection; every transition waits for the closing minor tick of a major cycle.
    always_comb begin
        w_nextState = r_state;
        w_orderDone = 1'b0;
        if (w_majorEnd) begin
            case (r_state)
                S_IDLE:     if (i_start_btn) w_nextState = S_STARTER;
                S_STARTER:  w_nextState = S_ORDER;
                S_ORDER:    w_nextState = S_EXEC;
                S_EXEC: begin
                    if (r_opV || r_opN) w_nextState = S_EXEC_EXT;
                    else                w_orderDone = 1'b1;
                end
                S_EXEC_EXT: if (r_extCnt == '0) w_orderDone = 1'b1;
                S_STOPPED: begin
                    if (i_single_step || (i_start_btn && !i_stop_btn)) w_nextState = S_ORDER;
                end
                default:    w_nextState = S_IDLE;
            endcase
            if (w_orderDone) begin
                w_nextState = (r_opZ || w_stopReqEff) ? S_STOPPED : S_ORDER;
            end
        end
    end

    // State register with registered stage outputs, latched order lines, stop request and strobes.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_extCnt     <= '0;
            r_stopReq    <= 1'b0;
            r_opZ        <= 1'b0;
            r_opE        <= 1'b0;
            r_opG        <= 1'b0;
            r_opV        <= 1'b0;
            r_opN        <= 1'b0;
            r_starter    <= 1'b0;
            r_orderStage <= 1'b0;
            r_execStage  <= 1'b0;
            r_extended   <= 1'b0;
            r_running    <= 1'b0;
            r_haltedZ    <= 1'b0;
            r_orderEntry <= 1'b0;
            r_tankLoad   <= 1'b0;
            r_sctInc     <= 1'b0;
            r_sctLoad    <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_starter    <= (w_nextState == S_STARTER);
            r_orderStage <= (w_nextState == S_ORDER);
            r_execStage  <= (w_nextState == S_EXEC) || (w_nextState == S_EXEC_EXT);
            r_extended   <= (w_nextState == S_EXEC_EXT);
            r_running    <= (w_nextState == S_STARTER) || (w_nextState == S_ORDER) ||
                            (w_nextState == S_EXEC)    || (w_nextState == S_EXEC_EXT);

            r_orderEntry <= (w_nextState == S_ORDER) && (r_state != S_ORDER);
            r_tankLoad   <= r_orderEntry;
            r_sctLoad    <= w_orderDone && w_jump;
            r_sctInc     <= w_orderDone && !w_jump;

            if (w_majorEnd && (r_state == S_ORDER)) begin
                r_opZ <= i_op_z;
                r_opE <= i_op_e;
                r_opG <= i_op_g;
                r_opV <= i_op_v;
                r_opN <= i_op_n;
            end

            if (w_majorEnd && (r_state == S_EXEC)) begin
                r_extCnt <= EXT_INIT;
            end else if (w_majorEnd && (r_state == S_EXEC_EXT) && (r_extCnt != '0)) begin
                r_extCnt <= r_extCnt - 1'b1;
            end

            if ((w_nextState == S_STOPPED) && (r_state != S_STOPPED)) begin
                r_stopReq <= 1'b0;
            end else if ((r_state == S_STOPPED) && (w_nextState == S_ORDER)) begin
                r_stopReq <= i_single_step;
            end else if (w_running && i_stop_btn) begin
                r_stopReq <= 1'b1;
            end

            if (w_orderDone) begin
                r_haltedZ <= r_opZ;
            end else if ((r_state == S_STOPPED) && (w_nextState == S_ORDER)) begin
                r_haltedZ <= 1'b0;
            end
        end
    end

    assign o_minor_count     = r_minorCount;
    assign o_major_end       = w_majorEnd;
    assign o_starter         = r_starter;
    assign o_starter_neg     = ~r_starter;
    assign o_order_stage     = r_orderStage;
    assign o_exec_stage      = r_execStage;
    assign o_extended        = r_extended;
    assign o_extended_neg    = ~r_extended;
    assign o_order_tank_load = r_tankLoad;
    assign o_sct_inc         = r_sctInc;
    assign o_sct_load        = r_sctLoad;
    assign o_running         = r_running;
    assign o_halted_z        = r_haltedZ;

endmodule

// File: tb/tb_edsac_main_control.sv
// Testbench for edsac_main_control: directed scenarios followed by random
// stimulus, all compared every cycle against a behavioural machine model.
module tb_edsac_main_control;

    localparam int MC  = 4;
    localparam int EXT = 1;
    localparam int MCW = 2;

    localparam int ST_IDLE    = 0;
    localparam int ST_STARTER = 1;
    localparam int ST_ORDER   = 2;
    localparam int ST_EXEC    = 3;
    localparam int ST_EXT     = 4;
    localparam int ST_STOPPED = 5;

    logic           clk = 1'b0;
    logic           rstN;
    logic           tick;
    logic           startBtn;
    logic           stopBtn;
    logic           singleStep;
    logic           opZ;
    logic           opE;
    logic           opG;
    logic           opV;
    logic           opN;
    logic           accNeg;
    logic [MCW-1:0] minorCount;
    logic           majorEnd;
    logic           starter;
    logic           starterNeg;
    logic           orderStage;
    logic           execStage;
    logic           extended;
    logic           extendedNeg;
    logic           orderTankLoad;
    logic           sctInc;
    logic           sctLoad;
    logic           running;
    logic           haltedZ;

    int errorCount = 0;
    int checkCount = 0;
    bit checkOn    = 1'b0;
    bit tickPhase  = 1'b0;

    int mStage;
    int mMinor;
    int mMajorsLeft;
    bit mStopReq;
    bit mHalted;
    bit mArm;
    bit lZ;
    bit lE;
    bit lG;
    bit lV;
    bit lN;
    bit eTank;
    bit eInc;
    bit eLoad;

    edsac_main_control #(
        .MINOR_CYCLES(MC),
        .EXT_MAJORS  (EXT),
        .MC_W        (MCW)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rstN),
        .i_minor_tick     (tick),
        .i_start_btn      (startBtn),
        .i_stop_btn       (stopBtn),
        .i_single_step    (singleStep),
        .i_op_z           (opZ),
        .i_op_e           (opE),
        .i_op_g           (opG),
        .i_op_v           (opV),
        .i_op_n           (opN),
        .i_acc_neg        (accNeg),
        .o_minor_count    (minorCount),
        .o_major_end      (majorEnd),
        .o_starter        (starter),
        .o_starter_neg    (starterNeg),
        .o_order_stage    (orderStage),
        .o_exec_stage     (execStage),
        .o_extended       (extended),
        .o_extended_neg   (extendedNeg),
        .o_order_tank_load(orderTankLoad),
        .o_sct_inc        (sctInc),
        .o_sct_load       (sctLoad),
        .o_running        (running),
        .o_halted_z       (haltedZ)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Minor tick strobe on every second clock, changed a little after the edge.
    always @(posedge clk) begin
        #2;
        tickPhase = ~tickPhase;
        tick      = tickPhase;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got %0d, want %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit s, input bit p, input bit st, input bit z, input bit e,
                                 input bit g, input bit v, input bit n, input bit neg);
        startBtn   = s;
        stopBtn    = p;
        singleStep = st;
        opZ        = z;
        opE        = e;
        opG        = g;
        opV        = v;
        opN        = n;
        accNeg     = neg;
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic enterOrder();
        mStage = ST_ORDER;
        mArm   = 1'b1;
    endtask

    // Machine-level reference: one call per clock edge, using the inputs seen at that edge.
    task automatic modelStep();
        bit endOfMajor;
        bit orderFinished;
        endOfMajor    = tick && (mMinor == MC - 1);
        orderFinished = 1'b0;
        eTank = mArm;
        mArm  = 1'b0;
        eInc  = 1'b0;
        eLoad = 1'b0;
        if (!rstN) begin
            mStage      = ST_IDLE;
            mMinor      = 0;
            mMajorsLeft = 0;
            mStopReq    = 1'b0;
            mHalted     = 1'b0;
            {lZ, lE, lG, lV, lN} = 5'b0;
            eTank       = 1'b0;
            return;
        end
        if (mStage >= ST_STARTER && mStage <= ST_EXT && stopBtn) mStopReq = 1'b1;
        if (endOfMajor) begin
            case (mStage)
                ST_IDLE:    if (startBtn) mStage = ST_STARTER;
                ST_STARTER: enterOrder();
                ST_ORDER: begin
                    {lZ, lE, lG, lV, lN} = {opZ, opE, opG, opV, opN};
                    mMajorsLeft = (opV || opN) ? 1 + EXT : 1;
                    mStage = ST_EXEC;
                end
                ST_EXEC, ST_EXT: begin
                    mMajorsLeft--;
                    if (mMajorsLeft == 0) orderFinished = 1'b1;
                    else                  mStage = ST_EXT;
                end
                ST_STOPPED: begin
                    if (singleStep) begin
                        enterOrder();
                        mStopReq = 1'b1;
                        mHalted  = 1'b0;
                    end else if (startBtn && !stopBtn) begin
                        enterOrder();
                        mHalted = 1'b0;
                    end
                end
                default: mStage = ST_IDLE;
            endcase
            if (orderFinished) begin
                if ((lE && !accNeg) || (lG && accNeg)) eLoad = 1'b1;
                else                                   eInc  = 1'b1;
                if (lZ || mStopReq) begin
                    mStage   = ST_STOPPED;
                    mHalted  = lZ;
                    mStopReq = 1'b0;
                end else begin
                    enterOrder();
                end
            end
        end
        if (tick) mMinor = (mMinor + 1) % MC;
    endtask

    // Advance the reference model on every rising edge.
    always @(posedge clk) modelStep();

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("minor_count", minorCount, mMinor);
            checkOutput("major_end", majorEnd, tick && (mMinor == MC - 1));
            checkOutput("starter", starter, mStage == ST_STARTER);
            checkOutput("starter_neg", starterNeg, mStage != ST_STARTER);
            checkOutput("order_stage", orderStage, mStage == ST_ORDER);
            checkOutput("exec_stage", execStage, (mStage == ST_EXEC) || (mStage == ST_EXT));
            checkOutput("extended", extended, mStage == ST_EXT);
            checkOutput("extended_neg", extendedNeg, mStage != ST_EXT);
            checkOutput("order_tank_load", orderTankLoad, eTank);
            checkOutput("sct_inc", sctInc, eInc);
            checkOutput("sct_load", sctLoad, eLoad);
            checkOutput("running", running, (mStage >= ST_STARTER) && (mStage <= ST_EXT));
            checkOutput("halted_z", haltedZ, mHalted);
        end
    end

    // Directed scenarios from the plan, then a long randomized run.
    initial begin
        rstN = 1'b0;
        tick = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 checkOn = 1'b1;
        runCycles(2);
        rstN = 1'b1;
        runCycles(3);

        $display("[TB] start from idle");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycles(8);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycles(40);

        $display("[TB] multiply and conditional jumps");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        runCycles(40);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        runCycles(40);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        runCycles(40);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
        runCycles(40);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
        runCycles(40);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
        runCycles(40);

        $display("[TB] Z order stop and resume");
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        runCycles(40);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycles(16);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycles(8);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycles(30);

        $display("[TB] stop button, single step, button combinations");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        runCycles(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycles(40);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        runCycles(8);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycles(48);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        runCycles(8);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
        runCycles(8);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycles(48);

        $display("[TB] reset during execute");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycles(8);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 200 && mStage != ST_EXEC; i++) runCycles(1);
        checkOutput("reached_exec", mStage == ST_EXEC, 1);
        runCycles(3);
        rstN = 1'b0;
        runCycles(1);
        rstN = 1'b1;
        runCycles(8);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycles(8);

        $display("[TB] random run");
        for (int i = 0; i < 3000; i++) begin
            rstN       = ($urandom_range(299) != 0);
            startBtn   = ($urandom_range(7) == 0);
            stopBtn    = ($urandom_range(15) == 0);
            singleStep = ($urandom_range(15) == 0);
            opZ        = ($urandom_range(9) == 0);
            opE        = ($urandom_range(2) == 0);
            opG        = ($urandom_range(2) == 0);
            opV        = ($urandom_range(3) == 0);
            opN        = ($urandom_range(4) == 0);
            accNeg     = 1'($urandom_range(1));
            runCycles(1);
        end

        runCycles(2);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
